// File: rtl/dck_loader.sv
// dck_loader: parses a TS2068 DCK cartridge stream arriving through data_io and
// turns every DOCK payload byte into a write at {chunk, offset} inside the DOCK
// region. It also publishes per-chunk presence and ROM maps for the dock decoder.
// Optional feature macro: DCK_FILL_EN. When defined, RAM chunks declared without
// data (type 1) are zero-filled with FILL_BYTE after the download ends.
module dck_loader #(
    parameter logic [7:0] DCK_INDEX = 8'd1,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  dock_map,
    output logic [7:0]  dock_rom,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BANK,
        S_TYPES,
`ifdef DCK_FILL_EN
        S_FILL,
`endif
        S_DATA
    } state_t;

    state_t          state, state_nxt;
    logic            act, act_q;
    logic            foreign, foreign_nxt;
    logic [2:0]      type_idx, type_idx_nxt;
    logic [7:0][1:0] type_sh, type_sh_nxt;
    logic [7:0]      data_mask, data_mask_nxt;
    logic [2:0]      chunk, chunk_nxt;
    logic [12:0]     offset, offset_nxt;
    logic            wr_en_nxt;
    logic [15:0]     wr_addr_nxt;
    logic [7:0]      wr_data_nxt;
    logic [7:0]      dock_map_nxt, dock_rom_nxt;
    logic            busy_nxt, error_nxt;
`ifdef DCK_FILL_EN
    logic [7:0]      fill_mask, fill_mask_nxt;
`else
    logic            unused_fill;
    assign unused_fill = ^{ce, FILL_BYTE};
`endif

    assign act = ioctl_download && (ioctl_index == DCK_INDEX);

    // Lowest set bit of mask at or above index 'from'; result is {found, index}.
    function automatic logic [3:0] find_from(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if ((i >= int'(from)) && mask[i]) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    // Next-state and next-output decode for the block parser.
    always_comb begin
        logic [7:0][1:0] type_new;
        logic [3:0]      hit;
        logic            end_dl;
        logic [7:0]      m_data, m_map, m_rom, m_fill;

        state_nxt     = state;
        foreign_nxt   = foreign;
        type_idx_nxt  = type_idx;
        type_sh_nxt   = type_sh;
        data_mask_nxt = data_mask;
        chunk_nxt     = chunk;
        offset_nxt    = offset;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        dock_map_nxt  = dock_map;
        dock_rom_nxt  = dock_rom;
        busy_nxt      = busy;
        error_nxt     = error;
`ifdef DCK_FILL_EN
        fill_mask_nxt = fill_mask;
`endif
        type_new = type_sh;
        hit      = 4'd0;
        end_dl   = 1'b0;
        m_data   = 8'd0;
        m_map    = 8'd0;
        m_rom    = 8'd0;
        m_fill   = 8'd0;

        case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (act && !act_q) begin
                    state_nxt    = S_BANK;
                    dock_map_nxt = 8'd0;
                    dock_rom_nxt = 8'd0;
                    error_nxt    = 1'b0;
                    busy_nxt     = 1'b1;
`ifdef DCK_FILL_EN
                    fill_mask_nxt = 8'd0;
`endif
                    if (ioctl_wr) begin
                        foreign_nxt  = (ioctl_dout != 8'd0);
                        type_idx_nxt = 3'd0;
                        state_nxt    = S_TYPES;
                    end
                end
            end
            S_BANK: begin
                if (!act) begin
                    end_dl = 1'b1;
                end else if (ioctl_wr) begin
                    foreign_nxt  = (ioctl_dout != 8'd0);
                    type_idx_nxt = 3'd0;
                    state_nxt    = S_TYPES;
                end
            end
            S_TYPES: begin
                if (!act) begin
                    error_nxt = 1'b1;
                    end_dl    = 1'b1;
                end else if (ioctl_wr) begin
                    if (ioctl_dout > 8'd3) begin
                        error_nxt          = 1'b1;
                        type_new[type_idx] = 2'd0;
                    end else begin
                        type_new[type_idx] = ioctl_dout[1:0];
                    end
                    type_sh_nxt  = type_new;
                    type_idx_nxt = type_idx + 3'd1;
                    if (type_idx == 3'd7) begin
                        for (int i = 0; i < 8; i++) begin
                            m_data[i] = type_new[i][1];
                            m_map[i]  = (type_new[i] != 2'd0);
                            m_rom[i]  = (type_new[i] == 2'd2);
                            m_fill[i] = (type_new[i] == 2'd1);
                        end
                        data_mask_nxt = m_data;
                        if (!foreign) begin
                            dock_map_nxt = m_map;
                            dock_rom_nxt = m_rom;
`ifdef DCK_FILL_EN
                            fill_mask_nxt = m_fill;
`endif
                        end
                        hit = find_from(m_data, 4'd0);
                        if (hit[3]) begin
                            state_nxt  = S_DATA;
                            chunk_nxt  = hit[2:0];
                            offset_nxt = 13'd0;
                        end else begin
                            state_nxt = S_BANK;
                        end
                    end
                end
            end
            S_DATA: begin
                if (!act) begin
                    error_nxt = 1'b1;
                    end_dl    = 1'b1;
                end else if (ioctl_wr) begin
                    if (!foreign) begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = {chunk, offset};
                        wr_data_nxt = ioctl_dout;
                    end
                    offset_nxt = offset + 13'd1;
                    if (offset == 13'h1FFF) begin
                        hit = find_from(data_mask, {1'b0, chunk} + 4'd1);
                        if (hit[3]) begin
                            chunk_nxt = hit[2:0];
                        end else begin
                            state_nxt = S_BANK;
                        end
                    end
                end
            end
`ifdef DCK_FILL_EN
            S_FILL: begin
                if (ce && !wr_en) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = {chunk, offset};
                    wr_data_nxt = FILL_BYTE;
                    offset_nxt  = offset + 13'd1;
                    if (offset == 13'h1FFF) begin
                        hit = find_from(fill_mask, {1'b0, chunk} + 4'd1);
                        if (hit[3]) begin
                            chunk_nxt = hit[2:0];
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (end_dl) begin
`ifdef DCK_FILL_EN
            hit = find_from(fill_mask, 4'd0);
            if (hit[3]) begin
                state_nxt  = S_FILL;
                chunk_nxt  = hit[2:0];
                offset_nxt = 13'd0;
            end else begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
`else
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
`endif
        end
    end

    // State register; reset aborts any download or fill immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers updated from the decode above.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act_q     <= 1'b0;
            foreign   <= 1'b0;
            type_idx  <= 3'd0;
            type_sh   <= '0;
            data_mask <= 8'd0;
            chunk     <= 3'd0;
            offset    <= 13'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 16'd0;
            wr_data   <= 8'd0;
            dock_map  <= 8'd0;
            dock_rom  <= 8'd0;
            busy      <= 1'b0;
            error     <= 1'b0;
`ifdef DCK_FILL_EN
            fill_mask <= 8'd0;
`endif
        end else begin
            act_q     <= act;
            foreign   <= foreign_nxt;
            type_idx  <= type_idx_nxt;
            type_sh   <= type_sh_nxt;
            data_mask <= data_mask_nxt;
            chunk     <= chunk_nxt;
            offset    <= offset_nxt;
            wr_en     <= wr_en_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            dock_map  <= dock_map_nxt;
            dock_rom  <= dock_rom_nxt;
            busy      <= busy_nxt;
            error     <= error_nxt;
`ifdef DCK_FILL_EN
            fill_mask <= fill_mask_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_dck_loader.sv
// tb_dck_loader: directed bench for dck_loader. Expected writes are queued when
// payload bytes are driven and matched in order against the DUT write port.
module tb_dck_loader;

    localparam logic [7:0] DCK_INDEX = 8'd1;
    localparam logic [7:0] FILL_BYTE = 8'h00;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clock;
    logic        reset;
    logic        ce;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  dock_map;
    logic [7:0]  dock_rom;
    logic        busy;
    logic        error;

    wr_t         sb[$];
    logic [7:0]  hdr[8];
    logic        prev_wr;
    int          tests;
    int          fails;

    dck_loader #(
        .DCK_INDEX(DCK_INDEX),
        .FILL_BYTE(FILL_BYTE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ce(ce),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_dout(ioctl_dout),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .dock_map(dock_map),
        .dock_rom(dock_rom),
        .busy(busy),
        .error(error)
    );

    // Free-running system clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Write-pacing strobe, one cycle high out of every two.
    initial begin
        ce = 1'b0;
        forever begin
            @(negedge clock);
            ce = ~ce;
        end
    end

    // Scoreboard consumer: every DUT write must match the oldest expectation.
    initial begin
        wr_t exp_wr;
        prev_wr = 1'b0;
        forever begin
            @(negedge clock);
            if (wr_en) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_write: observed addr %h data %h, expected no write", wr_addr, wr_data);
                end
                if (sb.size() != 0) begin
                    exp_wr = sb.pop_front();
                    tests++;
                    assert ({wr_addr, wr_data} === {exp_wr.addr, exp_wr.data}) else begin
                        fails++;
                        $error("FAIL write: observed addr %h data %h, expected addr %h data %h",
                               wr_addr, wr_data, exp_wr.addr, exp_wr.data);
                    end
                end
                tests++;
                assert (busy === 1'b1) else begin
                    fails++;
                    $error("FAIL busy_during_write: observed %b expected 1", busy);
                end
                tests++;
                assert (prev_wr === 1'b0) else begin
                    fails++;
                    $error("FAIL back_to_back_write: observed previous wr_en %b expected 0", prev_wr);
                end
            end
            prev_wr = wr_en;
        end
    end

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic expect_wr, input logic [15:0] addr);
        @(negedge clock);
        if (expect_wr) sb.push_back({addr, b});
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        @(negedge clock);
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_download();
        @(negedge clock);
        ioctl_index    = DCK_INDEX;
        ioctl_download = 1'b1;
        @(negedge clock);
    endtask

    task automatic end_download();
        @(negedge clock);
        ioctl_download = 1'b0;
    endtask

    task automatic clear_hdr();
        for (int i = 0; i < 8; i++) hdr[i] = 8'h00;
    endtask

    task automatic send_header(input logic [7:0] bank);
        send_byte(bank, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) send_byte(hdr[i], 1'b0, 16'h0000);
    endtask

    task automatic send_chunk(input logic dock, input logic [2:0] chunk, input int count);
        for (int i = 0; i < count; i++) begin
            send_byte(8'(i) + 8'(17 * int'(chunk)), dock, {chunk, 13'(i)});
        end
    endtask

    task automatic wait_not_busy(input string tag, input int bound);
        for (int c = 0; c < bound && busy; c++) @(negedge clock);
        @(negedge clock);
        check_output(tag, {15'd0, busy}, 16'd0);
    endtask

    // Directed sequence covering the DCK parsing scenarios.
    initial begin
        tests          = 0;
        fails          = 0;
        reset          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_dout     = 8'd0;
        repeat (3) @(negedge clock);
        check_output("reset_wr_en", {15'd0, wr_en}, 16'd0);
        check_output("reset_map", {8'd0, dock_map}, 16'd0);
        check_output("reset_rom", {8'd0, dock_rom}, 16'd0);
        check_output("reset_busy", {15'd0, busy}, 16'd0);
        check_output("reset_error", {15'd0, error}, 16'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single ROM chunk 0 with payload i & FF.
        start_download();
        check_output("a_busy_start", {15'd0, busy}, 16'd1);
        clear_hdr();
        hdr[0] = 8'h02;
        send_header(8'h00);
        send_chunk(1'b1, 3'd0, 8192);
        repeat (2) @(negedge clock);
        check_output("a_map", {8'd0, dock_map}, 16'h0001);
        check_output("a_rom", {8'd0, dock_rom}, 16'h0001);
        check_output("a_error", {15'd0, error}, 16'd0);
        end_download();
        wait_not_busy("a_busy_end", 1);
        check_output("a_write_count", 16'(sb.size()), 16'd0);

        // Foreign block consumed silently, then DOCK block with RAM 1 and ROM 3.
        start_download();
        clear_hdr();
        hdr[0] = 8'h02;
        send_header(8'hFE);
        send_chunk(1'b0, 3'd0, 8192);
        check_output("b_map_after_foreign", {8'd0, dock_map}, 16'h0000);
        clear_hdr();
        hdr[1] = 8'h03;
        hdr[3] = 8'h02;
        send_header(8'h00);
        check_output("b_map_header", {8'd0, dock_map}, 16'h000A);
        check_output("b_rom_header", {8'd0, dock_rom}, 16'h0008);
        send_chunk(1'b1, 3'd1, 8192);
        send_chunk(1'b1, 3'd3, 8192);
        repeat (2) @(negedge clock);
        end_download();
        wait_not_busy("b_busy_end", 1);
        check_output("b_map", {8'd0, dock_map}, 16'h000A);
        check_output("b_rom", {8'd0, dock_rom}, 16'h0008);
        check_output("b_error", {15'd0, error}, 16'd0);
        check_output("b_write_count", 16'(sb.size()), 16'd0);

        // Bad type byte at chunk 2 and a download cut after 100 payload bytes.
        start_download();
        clear_hdr();
        hdr[0] = 8'h02;
        hdr[2] = 8'h05;
        send_header(8'h00);
        check_output("c_error_type", {15'd0, error}, 16'd1);
        check_output("c_map", {8'd0, dock_map}, 16'h0001);
        send_chunk(1'b1, 3'd0, 100);
        repeat (2) @(negedge clock);
        end_download();
        wait_not_busy("c_busy_end", 1);
        check_output("c_error", {15'd0, error}, 16'd1);
        check_output("c_write_count", 16'(sb.size()), 16'd0);

        // Reset asserted in the middle of a chunk payload.
        start_download();
        clear_hdr();
        hdr[0] = 8'h03;
        send_header(8'h00);
        send_chunk(1'b1, 3'd0, 50);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_output("d_rst_wr_en", {15'd0, wr_en}, 16'd0);
        check_output("d_rst_busy", {15'd0, busy}, 16'd0);
        check_output("d_rst_map", {8'd0, dock_map}, 16'd0);
        check_output("d_rst_rom", {8'd0, dock_rom}, 16'd0);
        check_output("d_rst_error", {15'd0, error}, 16'd0);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        check_output("d_write_count", 16'(sb.size()), 16'd0);

        // Fresh download after reset: RAM chunk 0 declared without data.
        start_download();
        clear_hdr();
        hdr[0] = 8'h01;
        send_header(8'h00);
        @(negedge clock);
        check_output("e_map", {8'd0, dock_map}, 16'h0001);
        check_output("e_rom", {8'd0, dock_rom}, 16'h0000);
        check_output("e_busy", {15'd0, busy}, 16'd1);
`ifdef DCK_FILL_EN
        for (int i = 0; i < 8192; i++) sb.push_back({3'd0, 13'(i), FILL_BYTE});
        end_download();
        wait_not_busy("e_busy_end", 40000);
`else
        end_download();
        wait_not_busy("e_busy_end", 1);
`endif
        check_output("e_error", {15'd0, error}, 16'd0);
        check_output("e_write_count", 16'(sb.size()), 16'd0);
        check_output("e_map_end", {8'd0, dock_map}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
